// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//
// Shares one burst-oriented memory port between an I-cache (refill only) and a
// D-cache (refill or write-back). A request is granted in IDLE, the burst
// command is held in CMD until memory accepts it, LINE_WORDS data beats are
// counted in BEAT, and a one-cycle done pulse goes to the owner in DONE. When
// both caches ask at once, the one that was not granted last time wins.
//
// Ports
//   clk, rst_n                       core clock, synchronous active-low reset
//   ic_req_valid, ic_req_addr        I-cache line refill request
//   dc_req_valid, dc_req_we,
//   dc_req_addr, dc_wdata            D-cache request and write-back word
//   mem_req_valid/ready/addr/we      burst command handshake to memory
//   mem_beat_valid, mem_rdata        one data beat per cycle from memory
//   mem_wdata                        write-back word to memory
//   beat_idx                         word index within the current line
//   ic_rsp_valid, dc_rsp_valid,
//   rsp_data                         read beats routed to the owning cache
//   ic_done, dc_done                 one-cycle burst-complete pulse
//   ic_busy, dc_busy                 requester currently owns the port
// -----------------------------------------------------------------------------
module mem_arbiter #(
    parameter  int LINE_WORDS = 4,
    parameter  int ADDR_W     = 32,
    localparam int IDX_W      = $clog2(LINE_WORDS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ic_req_valid,
    input  logic [ADDR_W-1:0] ic_req_addr,
    input  logic              dc_req_valid,
    input  logic              dc_req_we,
    input  logic [ADDR_W-1:0] dc_req_addr,
    input  logic [31:0]       dc_wdata,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [ADDR_W-1:0] mem_req_addr,
    output logic              mem_req_we,
    input  logic              mem_beat_valid,
    input  logic [31:0]       mem_rdata,
    output logic [31:0]       mem_wdata,
    output logic [IDX_W-1:0]  beat_idx,
    output logic              ic_rsp_valid,
    output logic              dc_rsp_valid,
    output logic [31:0]       rsp_data,
    output logic              ic_done,
    output logic              dc_done,
    output logic              ic_busy,
    output logic              dc_busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CMD,
        S_BEAT,
        S_DONE
    } state_t;

    typedef enum logic {
        OWN_IC,
        OWN_DC
    } owner_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LINE_WORDS - 1);

    state_t            state;
    owner_t            owner;
    owner_t            last_grant;
    logic [ADDR_W-1:0] addr_q;
    logic              we_q;
    logic [IDX_W-1:0]  idx_q;
    logic              grant_dc;

    // D-cache wins if it is alone, or if both ask and the I-cache went last.
    assign grant_dc = dc_req_valid && (!ic_req_valid || last_grant == OWN_IC);

    // NOTE: state registers use non-blocking assignments so every register in
    // this block samples pre-edge values; the reset branch is inside the
    // clocked block because reset is synchronous here.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            owner      <= OWN_IC;
            last_grant <= OWN_IC;
            addr_q     <= '0;
            we_q       <= 1'b0;
            idx_q      <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (ic_req_valid || dc_req_valid) begin
                        if (grant_dc) begin
                            owner  <= OWN_DC;
                            addr_q <= dc_req_addr;
                            we_q   <= dc_req_we;
                        end else begin
                            owner  <= OWN_IC;
                            addr_q <= ic_req_addr;
                            we_q   <= 1'b0;   // I-cache only ever refills
                        end
                        state <= S_CMD;
                    end
                end
                S_CMD: begin
                    if (mem_req_ready) begin
                        idx_q <= '0;
                        state <= S_BEAT;
                    end
                end
                S_BEAT: begin
                    // Stalled beats hold everything; there is no timeout.
                    if (mem_beat_valid) begin
                        idx_q <= idx_q + IDX_W'(1);   // wraps to 0 after the last word
                        if (idx_q == LAST_IDX) begin
                            state <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    last_grant <= owner;
                    state      <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Outputs are decodes of registered state; only the data paths and the
    // per-beat valids pass memory/cache inputs straight through.
    logic in_beat;
    logic rd_beat;

    assign in_beat       = (state == S_BEAT);
    assign rd_beat       = in_beat && !we_q;

    assign mem_req_valid = (state == S_CMD);
    assign mem_req_addr  = addr_q;
    assign mem_req_we    = we_q;
    assign beat_idx      = idx_q;

    assign mem_wdata     = (in_beat && we_q) ? dc_wdata  : 32'h0;
    assign rsp_data      = rd_beat           ? mem_rdata : 32'h0;
    assign ic_rsp_valid  = rd_beat && mem_beat_valid && (owner == OWN_IC);
    assign dc_rsp_valid  = rd_beat && mem_beat_valid && (owner == OWN_DC);

    assign ic_done       = (state == S_DONE) && (owner == OWN_IC);
    assign dc_done       = (state == S_DONE) && (owner == OWN_DC);
    assign ic_busy       = (state != S_IDLE) && (owner == OWN_IC);
    assign dc_busy       = (state != S_IDLE) && (owner == OWN_DC);

`ifdef SIMULATION
    // ASCII tag naming the burst that completes this cycle, for stats scraping.
    logic [8*12-1:0] stats_event;

    always_comb begin
        stats_event = '0;
        if (state == S_DONE) begin
            stats_event = (owner == OWN_IC) ? "mem_ic_burst" : "mem_dc_burst";
        end
    end
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
//
// Directed scenarios for mem_arbiter with LINE_WORDS=4, ADDR_W=32. Inputs are
// driven 1 time unit after the rising edge and outputs are compared 1 unit
// later, well away from the next edge.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ic_req_valid;
    logic [31:0] ic_req_addr;
    logic        dc_req_valid;
    logic        dc_req_we;
    logic [31:0] dc_req_addr;
    logic [31:0] dc_wdata;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_req_addr;
    logic        mem_req_we;
    logic        mem_beat_valid;
    logic [31:0] mem_rdata;
    logic [31:0] mem_wdata;
    logic [1:0]  beat_idx;
    logic        ic_rsp_valid;
    logic        dc_rsp_valid;
    logic [31:0] rsp_data;
    logic        ic_done;
    logic        dc_done;
    logic        ic_busy;
    logic        dc_busy;

    int vecs = 0;
    int errs = 0;

    mem_arbiter #(.LINE_WORDS(4), .ADDR_W(32)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .ic_req_valid  (ic_req_valid),
        .ic_req_addr   (ic_req_addr),
        .dc_req_valid  (dc_req_valid),
        .dc_req_we     (dc_req_we),
        .dc_req_addr   (dc_req_addr),
        .dc_wdata      (dc_wdata),
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_req_addr  (mem_req_addr),
        .mem_req_we    (mem_req_we),
        .mem_beat_valid(mem_beat_valid),
        .mem_rdata     (mem_rdata),
        .mem_wdata     (mem_wdata),
        .beat_idx      (beat_idx),
        .ic_rsp_valid  (ic_rsp_valid),
        .dc_rsp_valid  (dc_rsp_valid),
        .rsp_data      (rsp_data),
        .ic_done       (ic_done),
        .dc_done       (dc_done),
        .ic_busy       (ic_busy),
        .dc_busy       (dc_busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, limit 200000", $time);
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        ic_req_valid   = 1'b0;
        ic_req_addr    = 32'h0;
        dc_req_valid   = 1'b0;
        dc_req_we      = 1'b0;
        dc_req_addr    = 32'h0;
        dc_wdata       = 32'h0;
        mem_req_ready  = 1'b0;
        mem_beat_valid = 1'b0;
        mem_rdata      = 32'h0;
    endtask

    // Reset wins over requests; every output is zero while and after reset.
    task automatic test_reset();
        idle_inputs();
        rst_n          = 1'b0;
        ic_req_valid   = 1'b1;
        dc_req_valid   = 1'b1;
        mem_beat_valid = 1'b1;
        mem_rdata      = 32'h1234_5678;
        dc_wdata       = 32'h5555_AAAA;
        tick();
        tick();
        vecs++;
        if ({mem_req_valid, mem_req_we, ic_busy, dc_busy, ic_done, dc_done,
             ic_rsp_valid, dc_rsp_valid} !== 8'h00) begin
            errs++;
            $display("FAIL reset_ctrl: got %b, want 00000000",
                     {mem_req_valid, mem_req_we, ic_busy, dc_busy, ic_done, dc_done,
                      ic_rsp_valid, dc_rsp_valid});
        end
        vecs++;
        if (beat_idx !== 2'd0 || mem_req_addr !== 32'h0) begin
            errs++;
            $display("FAIL reset_idx_addr: got idx %0d addr %h, want 0 and 0", beat_idx, mem_req_addr);
        end
        vecs++;
        if (rsp_data !== 32'h0 || mem_wdata !== 32'h0) begin
            errs++;
            $display("FAIL reset_data: got rsp %h wdata %h, want 0 and 0", rsp_data, mem_wdata);
        end
        idle_inputs();
        rst_n = 1'b1;
        tick();
    endtask

    // Single I-cache refill at 0x1000, ready and a beat every cycle. The
    // request cycle is cycle 1, CMD is cycle 2, beats are cycles 3..6 and
    // ic_done shows up in cycle 7.
    task automatic test_ic_refill();
        idle_inputs();
        ic_req_valid   = 1'b1;
        ic_req_addr    = 32'h0000_1000;
        mem_req_ready  = 1'b1;
        mem_beat_valid = 1'b1;
        #1;
        vecs++;
        if (mem_req_valid !== 1'b0 || ic_busy !== 1'b0) begin
            errs++;
            $display("FAIL ic_idle: got valid %b busy %b, want 0 0", mem_req_valid, ic_busy);
        end
        tick();
        vecs++;
        if ({mem_req_valid, mem_req_we, ic_busy, dc_busy} !== 4'b1010 || mem_req_addr !== 32'h1000) begin
            errs++;
            $display("FAIL ic_cmd: got v/we/icb/dcb %b addr %h, want 1010 addr 00001000",
                     {mem_req_valid, mem_req_we, ic_busy, dc_busy}, mem_req_addr);
        end
        for (int k = 0; k < 4; k++) begin
            tick();
            mem_rdata = 32'hC0DE_0000 + 32'(k);
            #1;
            vecs++;
            if (beat_idx !== 2'(k) || {ic_rsp_valid, dc_rsp_valid, ic_done} !== 3'b100
                || rsp_data !== 32'hC0DE_0000 + 32'(k) || mem_req_valid !== 1'b0) begin
                errs++;
                $display("FAIL ic_beat%0d: got idx %0d rsp %b%b done %b data %h mv %b, want idx %0d rsp 10 done 0 data %h mv 0",
                         k, beat_idx, ic_rsp_valid, dc_rsp_valid, ic_done, rsp_data, mem_req_valid,
                         k, 32'hC0DE_0000 + 32'(k));
            end
        end
        tick();
        #1;
        vecs++;
        if ({ic_done, dc_done, ic_rsp_valid, ic_busy} !== 4'b1001) begin
            errs++;
            $display("FAIL ic_done_cycle7: got done %b%b rsp %b busy %b, want 10 0 1",
                     ic_done, dc_done, ic_rsp_valid, ic_busy);
        end
        ic_req_valid = 1'b0;
        tick();
        vecs++;
        if ({ic_done, ic_busy, mem_req_valid} !== 3'b000) begin
            errs++;
            $display("FAIL ic_after_done: got done %b busy %b mv %b, want 000", ic_done, ic_busy, mem_req_valid);
        end
    endtask

    // Both caches hold their requests from reset: DC, then IC, then DC again,
    // each burst starting in the IDLE cycle right after the previous done.
    task automatic test_back_to_back();
        idle_inputs();
        rst_n = 1'b0;
        tick();
        rst_n          = 1'b1;
        ic_req_valid   = 1'b1;
        ic_req_addr    = 32'h0000_3000;
        dc_req_valid   = 1'b1;
        dc_req_we      = 1'b0;
        dc_req_addr    = 32'h0000_4000;
        mem_req_ready  = 1'b1;
        mem_beat_valid = 1'b1;
        mem_rdata      = 32'hBEEF_0000;
        for (int b = 0; b < 3; b++) begin
            logic        exp_dc;
            logic [31:0] exp_addr;
            exp_dc   = (b != 1);
            exp_addr = exp_dc ? 32'h4000 : 32'h3000;
            #1;
            vecs++;
            if ({ic_busy, dc_busy} !== 2'b00) begin
                errs++;
                $display("FAIL rr%0d_idle: got busy %b%b, want 00", b, ic_busy, dc_busy);
            end
            tick();
            vecs++;
            if ({ic_busy, dc_busy} !== {!exp_dc, exp_dc} || mem_req_addr !== exp_addr) begin
                errs++;
                $display("FAIL rr%0d_grant: got busy %b%b addr %h, want %b%b addr %h",
                         b, ic_busy, dc_busy, mem_req_addr, !exp_dc, exp_dc, exp_addr);
            end
            for (int k = 0; k < 4; k++) begin
                tick();
                vecs++;
                if ({ic_rsp_valid, dc_rsp_valid} !== {!exp_dc, exp_dc}) begin
                    errs++;
                    $display("FAIL rr%0d_beat%0d: got rsp %b%b, want %b%b",
                             b, k, ic_rsp_valid, dc_rsp_valid, !exp_dc, exp_dc);
                end
            end
            tick();
            vecs++;
            if ({ic_done, dc_done} !== {!exp_dc, exp_dc}) begin
                errs++;
                $display("FAIL rr%0d_done: got done %b%b, want %b%b", b, ic_done, dc_done, !exp_dc, exp_dc);
            end
            if (b == 2) idle_inputs();
            tick();
        end
    endtask

    // D-cache write-back at 0x2040; memory takes a word every other cycle.
    // The cache presents 0xA0 + beat_idx as its write word.
    task automatic test_writeback_stall();
        int exp_idx;
        int done_cnt;
        idle_inputs();
        dc_req_valid  = 1'b1;
        dc_req_we     = 1'b1;
        dc_req_addr   = 32'h0000_2040;
        mem_req_ready = 1'b1;
        tick();
        vecs++;
        if ({mem_req_valid, mem_req_we, dc_busy} !== 3'b111 || mem_req_addr !== 32'h2040) begin
            errs++;
            $display("FAIL wb_cmd: got v/we/busy %b addr %h, want 111 addr 00002040",
                     {mem_req_valid, mem_req_we, dc_busy}, mem_req_addr);
        end
        exp_idx  = 0;
        done_cnt = 0;
        for (int j = 0; j < 8; j++) begin
            tick();
            mem_beat_valid = (j % 2 == 1);
            dc_wdata       = 32'hA0 + 32'(beat_idx);
            #1;
            vecs++;
            if (beat_idx !== 2'(exp_idx) || mem_wdata !== 32'hA0 + 32'(exp_idx) || dc_rsp_valid !== 1'b0) begin
                errs++;
                $display("FAIL wb_cyc%0d: got idx %0d wdata %h rsp %b, want idx %0d wdata %h rsp 0",
                         j, beat_idx, mem_wdata, dc_rsp_valid, exp_idx, 32'hA0 + 32'(exp_idx));
            end
            if (dc_done) done_cnt++;
            if (mem_beat_valid) exp_idx++;
        end
        tick();
        mem_beat_valid = 1'b0;
        #1;
        vecs++;
        if (dc_done !== 1'b1) begin
            errs++;
            $display("FAIL wb_done: got %b, want 1", dc_done);
        end
        if (dc_done) done_cnt++;
        dc_req_valid = 1'b0;
        for (int j = 0; j < 3; j++) begin
            tick();
            if (dc_done) done_cnt++;
        end
        vecs++;
        if (done_cnt !== 1) begin
            errs++;
            $display("FAIL wb_done_count: got %0d pulses, want 1", done_cnt);
        end
    endtask

    // Memory holds off the command for 5 cycles; the command stays put even
    // while the requester scribbles on its address and stray beats arrive.
    task automatic test_cmd_stall();
        idle_inputs();
        ic_req_valid = 1'b1;
        ic_req_addr  = 32'h0000_5000;
        tick();
        for (int c = 0; c < 5; c++) begin
            ic_req_addr    = 32'hDEAD_0000 + 32'(c);
            mem_beat_valid = 1'b1;
            #1;
            vecs++;
            if ({mem_req_valid, mem_req_we, ic_busy} !== 3'b101 || mem_req_addr !== 32'h5000
                || beat_idx !== 2'd0 || ic_rsp_valid !== 1'b0) begin
                errs++;
                $display("FAIL cmd_stall%0d: got v/we/busy %b addr %h idx %0d rsp %b, want 101 addr 00005000 idx 0 rsp 0",
                         c, {mem_req_valid, mem_req_we, ic_busy}, mem_req_addr, beat_idx, ic_rsp_valid);
            end
            tick();
        end
        mem_req_ready  = 1'b1;
        mem_beat_valid = 1'b0;
        #1;
        vecs++;
        if (mem_req_valid !== 1'b1) begin
            errs++;
            $display("FAIL cmd_accept: got mem_req_valid %b, want 1", mem_req_valid);
        end
        tick();
        mem_req_ready  = 1'b0;
        mem_beat_valid = 1'b1;
        mem_rdata      = 32'h5A5A_0000;
        #1;
        vecs++;
        if (mem_req_valid !== 1'b0 || beat_idx !== 2'd0 || ic_rsp_valid !== 1'b1 || mem_req_addr !== 32'h5000) begin
            errs++;
            $display("FAIL cmd_first_beat: got mv %b idx %0d rsp %b addr %h, want 0 0 1 00005000",
                     mem_req_valid, beat_idx, ic_rsp_valid, mem_req_addr);
        end
        tick();
        tick();
        tick();
        tick();
        vecs++;
        if (ic_done !== 1'b1) begin
            errs++;
            $display("FAIL cmd_done: got %b, want 1", ic_done);
        end
        idle_inputs();
        tick();
    endtask

    // Reset during beat 2 aborts the burst silently; the still-asserted
    // request is then served again from beat 0.
    task automatic test_reset_midburst();
        idle_inputs();
        dc_req_valid   = 1'b1;
        dc_req_addr    = 32'h0000_6000;
        mem_req_ready  = 1'b1;
        mem_beat_valid = 1'b1;
        mem_rdata      = 32'h7777_0000;
        tick();
        tick();
        tick();
        tick();
        vecs++;
        if (beat_idx !== 2'd2 || dc_rsp_valid !== 1'b1) begin
            errs++;
            $display("FAIL rst_mid_setup: got idx %0d rsp %b, want 2 1", beat_idx, dc_rsp_valid);
        end
        rst_n = 1'b0;
        tick();
        vecs++;
        if ({mem_req_valid, dc_busy, dc_done, dc_rsp_valid, ic_busy, ic_done} !== 6'b0
            || beat_idx !== 2'd0 || rsp_data !== 32'h0) begin
            errs++;
            $display("FAIL rst_mid_abort: got ctrl %b idx %0d data %h, want 000000 0 0",
                     {mem_req_valid, dc_busy, dc_done, dc_rsp_valid, ic_busy, ic_done}, beat_idx, rsp_data);
        end
        rst_n = 1'b1;
        tick();
        vecs++;
        if (mem_req_valid !== 1'b1 || dc_busy !== 1'b1 || mem_req_addr !== 32'h6000 || dc_done !== 1'b0) begin
            errs++;
            $display("FAIL rst_mid_recmd: got mv %b busy %b addr %h done %b, want 1 1 00006000 0",
                     mem_req_valid, dc_busy, mem_req_addr, dc_done);
        end
        tick();
        vecs++;
        if (beat_idx !== 2'd0 || dc_rsp_valid !== 1'b1 || rsp_data !== 32'h7777_0000) begin
            errs++;
            $display("FAIL rst_mid_beat0: got idx %0d rsp %b data %h, want 0 1 77770000",
                     beat_idx, dc_rsp_valid, rsp_data);
        end
        tick();
        tick();
        tick();
        tick();
        vecs++;
        if (dc_done !== 1'b1) begin
            errs++;
            $display("FAIL rst_mid_done: got %b, want 1", dc_done);
        end
        idle_inputs();
        tick();
        vecs++;
        if (dc_done !== 1'b0 || dc_busy !== 1'b0) begin
            errs++;
            $display("FAIL rst_mid_idle: got done %b busy %b, want 0 0", dc_done, dc_busy);
        end
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_ic_refill();
        test_back_to_back();
        test_writeback_stall();
        test_cmd_stall();
        test_reset_midburst();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter LINE_WORDS, default 4, words per cache-line burst (power of two, 2..16).
REQ-002 Parameter ADDR_W, default 32, byte-address width.
REQ-003 clk  in  1  single core clock; all state on rising edge.
REQ-004 rst_n  in  1  reset, synchronous, active-low.
REQ-005 ic_req_valid  in  1  I-cache refill request; held high until ic_done.
REQ-006 ic_req_addr  in  ADDR_W  I-cache line address, line-aligned.
REQ-007 dc_req_valid  in  1  D-cache request; held high until dc_done.
REQ-008 dc_req_we  in  1  1 = write-back burst, 0 = refill.
REQ-009 dc_req_addr  in  ADDR_W  D-cache line address, line-aligned.
REQ-010 dc_wdata  in  32  write-back word selected by beat_idx.
REQ-011 mem_req_valid  out  1  burst command valid to memory.
REQ-012 mem_req_ready  in  1  memory accepts command.
REQ-013 mem_req_addr, mem_req_we  out  ADDR_W, 1  command address and direction.
REQ-014 mem_beat_valid  in  1  one data beat transferred (read data valid or write word consumed).
REQ-015 mem_rdata  in  32  read beat data; mem_wdata  out  32  write beat data.
REQ-016 beat_idx  out  log2(LINE_WORDS)  current word index within line.
REQ-017 ic_rsp_valid, dc_rsp_valid  out  1 each  read beat for owner; rsp_data  out  32.
REQ-018 ic_done, dc_done  out  1 each  one-cycle burst-complete pulse.
REQ-019 ic_busy, dc_busy  out  1 each  requester owns memory port.

Function
REQ-020 FSM states SHALL be IDLE, CMD, BEAT, DONE.
REQ-021 IDLE: any request valid -> latch owner, address, we; go CMD next cycle.
REQ-022 Both valid in IDLE SHALL grant the requester not granted last (round-robin via last_grant register).
REQ-023 CMD: mem_req_valid=1 with latched addr/we; mem_req_ready=1 -> BEAT, beat_idx=0.
REQ-024 BEAT: each cycle with mem_beat_valid=1 SHALL increment beat_idx; at beat_idx=LINE_WORDS-1 with beat -> DONE.
REQ-025 Cycles in BEAT without mem_beat_valid SHALL hold beat_idx and all outputs (no timeout).
REQ-026 Read burst: owner's rsp_valid = mem_beat_valid in BEAT, rsp_data = mem_rdata, combinational; non-owner rsp_valid=0.
REQ-027 Write burst: mem_wdata = dc_wdata, combinational; ic_req_we does not exist, I-cache bursts are always reads.
REQ-028 DONE: owner's done=1 for exactly one cycle; last_grant <= owner; -> IDLE.
REQ-029 Minimum burst latency SHALL be LINE_WORDS+3 cycles from grant (IDLE sample) to done pulse with ready and beats every cycle.
REQ-030 Back-to-back: requester re-asserting in cycle after done SHALL be arbitrated normally in IDLE; no bubble beyond IDLE.
REQ-031 Request dropped mid-burst SHALL be ignored; burst completes to memory protocol end.
REQ-032 busy = (state != IDLE) & owner match; at most one busy high.
REQ-033 Latched address/we SHALL not change from CMD through DONE regardless of input changes.
REQ-034 mem_req_valid SHALL be 0 outside CMD; rsp_valid, done 0 outside BEAT/DONE respectively.
REQ-035 Under SIMULATION, DONE SHALL report stats_event "mem_ic_burst" or "mem_dc_burst".

Reset
REQ-036 rst_n=0 at clock edge: state=IDLE, beat_idx=0, owner=IC, last_grant=IC, all outputs 0.
REQ-037 Reset mid-burst SHALL abort immediately; no done pulse issued.
REQ-038 First simultaneous request after reset SHALL grant D-cache.

Verification
REQ-039 IC refill only, addr 0x1000, ready and beats every cycle -> mem_req_addr=0x1000 we=0, 4 ic_rsp_valid beats idx 0..3, ic_done 7 cycles after request.
REQ-040 IC and DC read both valid after reset -> DC served first, IC next, DC again if re-requested (alternation).
REQ-041 DC write-back addr 0x2040, dc_wdata=0xA0+idx, beats stalled every other cycle -> mem_wdata 0xA0..0xA3 in order, idx holds during stalls, dc_done once.
REQ-042 mem_req_ready low 5 cycles in CMD -> mem_req_valid and addr stable all 5 cycles; no beats counted.
REQ-043 rst_n low during beat 2 -> next cycle IDLE, no done, outputs 0; new request served from beat 0.
